// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit: op codes, FSM states and the
// two's-complement helper used for operand magnitudes and result sign fix-up.
package muldiv_pkg;

  localparam int RD_W  = 5;
  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  // Conditional negate; callers zero-extend to MAX_W and truncate the result.
  function automatic logic [MAX_W-1:0] twos_mag(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between operand read, the muldiv unit and writeback.
// master = core side issuing requests, slave = muldiv_unit.
interface muldiv_unit_if
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [RD_W-1:0]       rd_in;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic [RD_W-1:0]       rd_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_core.sv
// Unsigned iterative datapath: one shift-add (multiply) or restoring shift-subtract
// (divide) step per cycle on a shared 2W accumulator; acc_nxt is the post-step value.
module muldiv_core #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic           is_div,
  input  logic [W-1:0]   ld_opnd,
  input  logic [W-1:0]   ld_lo,
  output logic [2*W-1:0] acc_nxt,
  output logic           last
);
  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     mul_sum, rem_shift, rem_diff;

  // Multiply: acc = {partial_hi, multiplier}. Divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, {W{acc_q[0]}} & opnd_q};
    rem_shift = acc_q[2*W-1:W-1];
    rem_diff  = rem_shift - {1'b0, opnd_q};
    if (is_div) begin
      acc_nxt = rem_diff[W] ? {rem_shift[W-1:0], acc_q[W-2:0], 1'b0}
                            : {rem_diff[W-1:0],  acc_q[W-2:0], 1'b1};
    end else begin
      acc_nxt = {mul_sum, acc_q[W-1:1]};
    end

    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    if (load) begin
      acc_d  = {{W{1'b0}}, ld_lo};
      opnd_d = ld_opnd;
      cnt_d  = '0;
    end else if (step) begin
      acc_d  = acc_nxt;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  assign last = step && (cnt_q == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M mul/div unit: done pulses N+1 cycles after start (1 cycle for div-by-zero/overflow);
// start ignored while busy. Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_unit_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int W2 = 2 * DATA_WIDTH;

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q, op_d, op_in;
  logic            neg_q, neg_d;
  logic [RD_W-1:0] rd_pend_q, rd_pend_d;
  logic [RD_W-1:0] rd_out_q, rd_out_d;
  logic [W-1:0]    result_q, result_d;

  logic            a_sgn, b_sgn, a_neg, b_neg, in_div, in_rem, b_zero, ovf, special, neg_in;
  logic [W-1:0]    a_mag, b_mag, spec_val, ld_opnd, ld_lo;
  logic            core_load, core_step, core_last, calc_div;
  logic [W2-1:0]   core_acc, prod_s;
  logic [W-1:0]    div_raw, calc_res;
`ifdef MULDIV_FAST_MUL_EN
  logic [W2-1:0]   fast_prod, fast_signed;
  logic [W-1:0]    fast_res;
`endif

  // Request decode: sign flags, magnitudes and the short-circuit divide cases.
  always_comb begin
    op_in  = muldiv_op_e'(bus.funct3);
    a_sgn  = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_sgn  = op_in inside {OP_MULH, OP_DIV, OP_REM};
    a_neg  = a_sgn & bus.op_a[W-1];
    b_neg  = b_sgn & bus.op_b[W-1];
    a_mag  = W'(twos_mag(MAX_W'(bus.op_a), a_neg));
    b_mag  = W'(twos_mag(MAX_W'(bus.op_b), b_neg));
    in_div = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    in_rem = op_in inside {OP_REM, OP_REMU};
    neg_in = (in_div && in_rem) ? a_neg : (a_neg ^ b_neg);
    b_zero = (bus.op_b == '0);
    ovf    = (op_in inside {OP_DIV, OP_REM}) && (bus.op_a == {1'b1, {(W-1){1'b0}}})
             && (bus.op_b == '1);
    special = in_div && (b_zero || ovf);
    if (b_zero) spec_val = in_rem ? bus.op_a : '1;
    else        spec_val = in_rem ? '0 : bus.op_a;
    ld_opnd = in_div ? b_mag : a_mag;
    ld_lo   = in_div ? a_mag : b_mag;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod   = W2'(a_mag) * W2'(b_mag);
    fast_signed = W2'(twos_mag(MAX_W'(fast_prod), neg_in));
    fast_res    = (op_in == OP_MUL) ? fast_signed[W-1:0] : fast_signed[W2-1:W];
`endif
  end

  // Sign fix-up of the final iteration, taken from the core's post-step value.
  always_comb begin
    calc_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    prod_s   = W2'(twos_mag(MAX_W'(core_acc), neg_q));
    div_raw  = (op_q inside {OP_REM, OP_REMU}) ? core_acc[W2-1:W] : core_acc[W-1:0];
    if (calc_div)            calc_res = W'(twos_mag(MAX_W'(div_raw), neg_q));
    else if (op_q == OP_MUL) calc_res = prod_s[W-1:0];
    else                     calc_res = prod_s[W2-1:W];
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rd_pend_d = rd_pend_q;
    rd_out_d  = rd_out_q;
    result_d  = result_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d      = op_in;
          neg_d     = neg_in;
          rd_pend_d = bus.rd_in;
          core_load = 1'b1;
          if (special) begin
            result_d = spec_val;
            rd_out_d = bus.rd_in;
            state_d  = DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!in_div) begin
            result_d = fast_res;
            rd_out_d = bus.rd_in;
            state_d  = DONE;
`endif
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        core_step = 1'b1;
        if (core_last) begin
          result_d = calc_res;
          rd_out_d = rd_pend_q;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  muldiv_core #(.W(W)) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (core_load),
    .step    (core_step),
    .is_div  (calc_div),
    .ld_opnd (ld_opnd),
    .ld_lo   (ld_lo),
    .acc_nxt (core_acc),
    .last    (core_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      rd_pend_q <= '0;
      rd_out_q  <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rd_pend_q <= rd_pend_d;
      rd_out_q  <= rd_out_d;
      result_q  <= result_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: hand-computed results, latency, rd passthrough,
// ignored starts (busy and DONE cycle) and mid-operation reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int DW = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk;
  logic reset;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  muldiv_unit_if #(.DATA_WIDTH(DW)) mif();

  muldiv_unit #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic add_vec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input int lat);
    vec_t v;
    v.f3 = f3; v.a = a; v.b = b; v.rd = rd; v.res = res; v.lat = lat;
    vq.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    mif.funct3 = v.f3;
    mif.op_a   = v.a;
    mif.op_b   = v.b;
    mif.rd_in  = v.rd;
    mif.start  = 1'b1;
    @(posedge clk); #1;
    mif.start = 1'b0;
    lat = 1;
    while (mif.done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d_lat", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d_res", idx), mif.result, v.res);
    chk($sformatf("v%0d_rd", idx), 32'(mif.rd_out), 32'(v.rd));
    // A start presented during the DONE cycle must not launch a new operation.
    mif.funct3 = 3'd5;
    mif.op_a   = 32'd99;
    mif.op_b   = 32'd5;
    mif.rd_in  = 5'd31;
    mif.start  = 1'b1;
    @(posedge clk); #1;
    mif.start = 1'b0;
    chk($sformatf("v%0d_done_ign_busy", idx), 32'(mif.busy), 32'd0);
    chk($sformatf("v%0d_done_1cyc", idx), 32'(mif.done), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_hold_res", idx), mif.result, v.res);
    chk($sformatf("v%0d_hold_rd", idx), 32'(mif.rd_out), 32'(v.rd));
  endtask

  initial begin
    int lat;
    int pulses;

    reset      = 1'b1;
    mif.start  = 1'b0;
    mif.funct3 = 3'd0;
    mif.op_a   = '0;
    mif.op_b   = '0;
    mif.rd_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(mif.busy),   32'd0);
    chk("rst_done",   32'(mif.done),   32'd0);
    chk("rst_result", mif.result,      32'd0);
    chk("rst_rd",     32'(mif.rd_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    add_vec(3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT);
    add_vec(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, MUL_LAT);
    add_vec(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, MUL_LAT);
    add_vec(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, MUL_LAT);
    add_vec(3'd0, 32'h1234_5678, 32'h0000_0010, 5'd9,  32'h2345_6780, MUL_LAT);
    add_vec(3'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 5'd10, 32'h0000_0014, MUL_LAT);
    add_vec(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd11, 32'h4000_0000, MUL_LAT);
    add_vec(3'd3, 32'd3,        32'd5,         5'd0,  32'h0000_0000, MUL_LAT);
    add_vec(3'd4, 32'hFFFF_FFEC, 32'd6,         5'd12, 32'hFFFF_FFFD, DIV_LAT);
    add_vec(3'd6, 32'hFFFF_FFEC, 32'd6,         5'd13, 32'hFFFF_FFFE, DIV_LAT);
    add_vec(3'd4, 32'd20,       32'hFFFF_FFFA, 5'd14, 32'hFFFF_FFFD, DIV_LAT);
    add_vec(3'd6, 32'd20,       32'hFFFF_FFFA, 5'd15, 32'h0000_0002, DIV_LAT);
    add_vec(3'd5, 32'd100,      32'd7,         5'd16, 32'd14,        DIV_LAT);
    add_vec(3'd7, 32'd100,      32'd7,         5'd17, 32'd2,         DIV_LAT);
    add_vec(3'd5, 32'hFFFF_FFFF, 32'd1,         5'd18, 32'hFFFF_FFFF, DIV_LAT);
    add_vec(3'd7, 32'hFFFF_FFFF, 32'h10,        5'd19, 32'h0000_000F, DIV_LAT);
    add_vec(3'd4, 32'h8000_0000, 32'd2,         5'd20, 32'hC000_0000, DIV_LAT);
    add_vec(3'd5, 32'h0000_1234, 32'd0,         5'd21, 32'hFFFF_FFFF, 1);
    add_vec(3'd7, 32'h0000_1234, 32'd0,         5'd22, 32'h0000_1234, 1);
    add_vec(3'd4, 32'hFFFF_FFFB, 32'd0,         5'd23, 32'hFFFF_FFFF, 1);
    add_vec(3'd6, 32'hFFFF_FFFB, 32'd0,         5'd24, 32'hFFFF_FFFB, 1);
    add_vec(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd25, 32'h8000_0000, 1);
    add_vec(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd26, 32'h0000_0000, 1);

    foreach (vq[i]) run_vec(vq[i], i);

    // Second start while busy must be ignored: DIVU 1000/3 still completes as issued.
    @(negedge clk);
    mif.funct3 = 3'd5; mif.op_a = 32'd1000; mif.op_b = 32'd3; mif.rd_in = 5'd9;
    mif.start  = 1'b1;
    @(posedge clk); #1;
    mif.start = 1'b0;
    lat = 1;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    @(negedge clk);
    mif.funct3 = 3'd5; mif.op_a = 32'd7; mif.op_b = 32'd7; mif.rd_in = 5'd2;
    mif.start  = 1'b1;
    @(posedge clk); #1;
    mif.start = 1'b0;
    lat++;
    chk("busy_ign_busy", 32'(mif.busy), 32'd1);
    while (mif.done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_ign_lat", 32'(lat), 32'd33);
    chk("busy_ign_res", mif.result, 32'd333);
    chk("busy_ign_rd",  32'(mif.rd_out), 32'd9);
    @(posedge clk); #1;

    // Reset mid-operation aborts without a done pulse and clears the result.
    @(negedge clk);
    mif.funct3 = 3'd5; mif.op_a = 32'd1000; mif.op_b = 32'd3; mif.rd_in = 5'd11;
    mif.start  = 1'b1;
    @(posedge clk); #1;
    mif.start = 1'b0;
    lat    = 1;
    pulses = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (mif.done === 1'b1) pulses++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy",   32'(mif.busy),   32'd0);
    chk("abort_done",   32'(mif.done),   32'd0);
    chk("abort_result", mif.result,      32'd0);
    chk("abort_rd",     32'(mif.rd_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (mif.done === 1'b1) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    chk("abort_idle",    32'(mif.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
